inst_fetch: RTL and testbench

- Instruction-fetch responder at the output of the PC register: takes the current fetch PC and runs one transaction on the SRAM-like instruction bus.
- Holds the returned word for the IF/ID register.
- Raises a stall request to the pipeline stall controller until the word is ready.
- One transaction outstanding at most; a flush cancels in-flight fetches safely.

---
 rtl/inst_fetch.sv | 96 +++++++++
 tb/tb_inst_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch responder: issues one read per fetch PC on the SRAM-like
// instruction bus, holds the returned word for IF/ID and requests a pipeline
// stall until that word is ready. A flush drops whatever is still in flight.
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_adel,
  output logic        stallreq_if
);

  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {StIdle, StWait, StDone, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_adel_q;
  logic        pc_misaligned;

  // Only stall[1] (the IF stage slot) matters here; the rest belong to other stages.
  logic        unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign pc_misaligned = |pc[1:0];

  // Request straight from the PC register; PC is frozen by stallreq_if, so no re-latch.
  assign inst_req    = !reset && (state_q == StIdle) && !flush && !pc_misaligned;
  assign inst_addr   = pc;
  assign inst_valid  = !reset && (state_q == StDone);
  assign stallreq_if = reset || (state_q != StDone);

  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign inst_adel = inst_adel_q;

  // Fetch sequencing and the held IF/ID word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      inst_adel_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!flush) begin
            if (pc_misaligned) begin
              // Address error is reported as a completed fetch with no bus traffic.
              inst_q      <= '0;
              inst_pc_q   <= pc;
              inst_adel_q <= 1'b1;
              state_q     <= StDone;
            end else if (inst_addr_ok) begin
              inst_pc_q <= pc;
              state_q   <= StWait;
            end
          end
        end
        StWait: begin
          if (flush) begin
            // Data arriving with the flush closes the transaction, nothing left to drop.
            state_q <= inst_data_ok ? StIdle : StDiscard;
          end else if (inst_data_ok) begin
            inst_q      <= inst_rdata;
            inst_adel_q <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (flush || (stall[1] == NoStop)) begin
            state_q <= StIdle;
          end
        end
        StDiscard: begin
          if (inst_data_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run where the
// bench plays bus slave, PC register and stall controller, and predicts outputs
// from fetch-level bookkeeping (outstanding read, cancelled read, current PC).
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_adel;
  logic        stallreq_if;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_adel    (inst_adel),
    .stallreq_if  (stallreq_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents the bench slave returns for a given address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'h0f0f};
  endfunction

  initial begin
    bit          outst;
    bit          canc;
    bit          prev_f;
    int          dly;
    int          exp_v;
    int          since_v;
    logic [31:0] acc;
    logic [31:0] pc_nxt;
    logic [31:0] r;

    reset = 1'b1; pc = 32'hBFC00000; stall = '0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    // Reset state
    @(negedge clk); #1;
    chk("reset_req", inst_req, 0);
    chk("reset_stallreq", stallreq_if, 1);
    chk("reset_valid", inst_valid, 0);
    chk("reset_inst", inst, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_adel", inst_adel, 0);

    // Zero-wait fetch
    @(negedge clk); reset = 1'b0; stall = 6'b000011; inst_addr_ok = 1'b1; #1;
    chk("zw_req", inst_req, 1);
    chk("zw_addr", inst_addr, 32'hBFC00000);
    chk("zw_stallreq", stallreq_if, 1);
    @(negedge clk); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C08BFC0; #1;
    chk("zw_wait_req", inst_req, 0);
    chk("zw_wait_valid", inst_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; inst_rdata = '0; stall = 6'b000000; #1;
    chk("zw_valid", inst_valid, 1);
    chk("zw_inst", inst, 32'h3C08BFC0);
    chk("zw_inst_pc", inst_pc, 32'hBFC00000);
    chk("zw_stallreq_low", stallreq_if, 0);

    // Misaligned PC
    @(negedge clk); pc = 32'h80000002; stall = 6'b000011; #1;
    chk("zw_valid_one_cycle", inst_valid, 0);
    chk("zw_stallreq_back", stallreq_if, 1);
    chk("mis_no_req", inst_req, 0);
    @(negedge clk); #1;
    chk("mis_valid", inst_valid, 1);
    chk("mis_adel", inst_adel, 1);
    chk("mis_inst", inst, 0);
    chk("mis_inst_pc", inst_pc, 32'h80000002);
    chk("mis_no_req_done", inst_req, 0);
    stall = 6'b000000;

    // Slow slave: three refused request cycles, accepted on the fourth
    @(negedge clk); pc = 32'h80001000; stall = 6'b000011;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      inst_addr_ok = (i == 3);
      #1;
      chk("ss_req", inst_req, 1);
      chk("ss_addr", inst_addr, 32'h80001000);
      chk("ss_stallreq", stallreq_if, 1);
      chk("ss_valid", inst_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = (i == 3);
      inst_rdata = (i == 3) ? 32'h1234ABCD : 32'hFFFFFFFF;
      #1;
      chk("ss_wait_req", inst_req, 0);
      chk("ss_wait_stallreq", stallreq_if, 1);
      chk("ss_wait_valid", inst_valid, 0);
    end

    // Downstream stall holds DONE
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); inst_data_ok = 1'b0; inst_rdata = '0; stall = 6'b000011; #1;
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, 32'h1234ABCD);
      chk("hold_inst_pc", inst_pc, 32'h80001000);
      chk("hold_stallreq", stallreq_if, 0);
    end
    @(negedge clk); stall = 6'b000000; #1;
    chk("hold_last_valid", inst_valid, 1);

    // Flush while in WAIT
    @(negedge clk); pc = 32'h80002000; stall = 6'b000011; inst_addr_ok = 1'b1; #1;
    chk("hold_release_valid", inst_valid, 0);
    chk("fl_req", inst_req, 1);
    @(negedge clk); inst_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("fl_wait_req", inst_req, 0);
    @(negedge clk); flush = 1'b0; pc = 32'h80003000; #1;
    chk("fl_disc_req", inst_req, 0);
    chk("fl_disc_valid", inst_valid, 0);
    @(negedge clk); inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
    chk("fl_data_req", inst_req, 0);
    chk("fl_data_valid", inst_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; inst_rdata = '0; inst_addr_ok = 1'b1; #1;
    chk("fl_next_req", inst_req, 1);
    chk("fl_next_addr", inst_addr, 32'h80003000);
    chk("fl_dropped_valid", inst_valid, 0);

    // Reset during WAIT
    @(negedge clk); inst_addr_ok = 1'b0; reset = 1'b1; #1;
    chk("rw_req_in_reset", inst_req, 0);
    chk("rw_valid_in_reset", inst_valid, 0);
    @(negedge clk); #1;
    chk("rw_valid", inst_valid, 0);
    chk("rw_inst", inst, 0);
    chk("rw_inst_pc", inst_pc, 0);
    chk("rw_stallreq", stallreq_if, 1);
    reset = 1'b0;
    pc = 32'h80010000;

    // Randomized run against fetch-level bookkeeping
    outst = 1'b0; canc = 1'b0; prev_f = 1'b0; dly = 0; exp_v = 0; since_v = 0;
    acc = '0; pc_nxt = 32'h80010000;
    for (int n = 0; n < 3000; n++) begin
      logic f, v, req, dok, aok, s, mis;
      @(negedge clk);
      pc = pc_nxt;
      f = !prev_f && ($urandom_range(0, 31) == 0);
      flush = f;
      dok = outst && (dly == 0);
      inst_data_ok = dok;
      inst_rdata = dok ? mem_word(acc) : $urandom;
      #1;
      v   = inst_valid;
      req = inst_req;
      mis = |pc[1:0];
      s   = stallreq_if || (v && ($urandom_range(0, 2) == 0));
      stall = {4'b0000, s, s};
      aok = req && ($urandom_range(0, 2) == 0);
      inst_addr_ok = aok;

      chk("rnd_valid", v, exp_v);
      chk("rnd_req", req, !v && !outst && !f && !mis);
      chk("rnd_stallreq", stallreq_if, !v);
      if (req) chk("rnd_addr", inst_addr, pc);
      if (v) begin
        chk("rnd_inst_pc", inst_pc, pc);
        chk("rnd_adel", inst_adel, mis);
        chk("rnd_inst", inst, mis ? 32'h0 : mem_word(pc));
      end
      since_v = v ? 0 : since_v + 1;
      chk("rnd_progress", 32'(since_v > 200), 0);
      if (since_v > 200) break;

      // Expected inst_valid next cycle, from what this cycle completed or released.
      if (v) exp_v = (!f && s) ? 1 : 0;
      else if (dok && !canc && !f) exp_v = 1;
      else if (!outst && !f && mis) exp_v = 1;
      else exp_v = 0;

      // Bus slave bookkeeping: one read in flight, returned 1..4 cycles after accept.
      if (dok) begin
        outst = 1'b0;
        canc  = 1'b0;
      end else if (outst) begin
        dly--;
        if (f) canc = 1'b1;
      end
      if (aok) begin
        outst = 1'b1;
        acc   = pc;
        dly   = $urandom_range(0, 3);
      end

      // PC register: redirect on flush, advance when IF is not stalled.
      r = $urandom;
      if (f) pc_nxt = ($urandom_range(0, 5) == 0) ? {r[31:2], 2'b10} : {r[31:2], 2'b00};
      else if (!s) pc_nxt = ($urandom_range(0, 7) == 0) ? {r[31:2], 2'b01} : pc + 32'd4;
      prev_f = f;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
